ubrcl_seq_arb: RTL and testbench

UBRCL_SEQ_ARB -- requirements
Module: ubrcl_seq_arb

---
 rtl/ubrcl_seq_arb.sv | 185 ++++++++++++++++++
 tb/tb_ubrcl_seq_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ubrcl_seq_arb.sv
// ubrcl_seq_arb: two-requester round-robin front end feeding a sequential
// carry look-ahead adder that produces one BW-bit block of the sum per cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grant and ready are combinational
// CALC  | adding one BW-bit block per cycle, LSB block first
// DONE  | result valid on S/OID/OV, held until the consumer takes it
module ubrcl_seq_arb #(
    parameter int XW = 8,
    parameter int YW = 12,
    parameter int BW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [XW-1:0] X0,
    input  logic [YW-1:0] Y0,
    input  logic          V0,
    output logic          R0,
    input  logic [XW-1:0] X1,
    input  logic [YW-1:0] Y1,
    input  logic          V1,
    output logic          R1,
    output logic [YW:0]   S,
    output logic          OID,
    output logic          OV,
    input  logic          OR
);

    localparam int NB = YW / BW;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [YW-1:0] a_q, a_d;
    logic [YW-1:0] b_q, b_d;
    logic [YW:0]   s_q, s_d;
    logic          oid_q, oid_d;
    logic          ov_q, ov_d;
    logic          cy_q, cy_d;
    logic          last_q, last_d;
    logic [KW-1:0] blk_q, blk_d;

    logic          grant;
    logic          acc0;
    logic          acc1;

    logic [BW-1:0] blk_a;
    logic [BW-1:0] blk_b;
    logic [BW-1:0] blk_g;
    logic [BW-1:0] blk_p;
    logic [BW:0]   blk_c;
    logic [BW-1:0] blk_sum;

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant = ~last_q;
        if (V0 && !V1) begin
            grant = 1'b0;
        end else if (V1 && !V0) begin
            grant = 1'b1;
        end
    end

    // Ready is only offered from IDLE and never while reset is asserted.
    assign R0   = (state_q == IDLE) && !RST && !grant;
    assign R1   = (state_q == IDLE) && !RST && grant;
    assign acc0 = V0 && R0;
    assign acc1 = V1 && R1;

    // Carry look-ahead for the current block; each carry is the flat
    // generate/propagate expansion back to the block carry-in.
    always_comb begin
        logic c_acc;
        blk_a = '0;
        blk_b = '0;
        for (int j = 0; j < NB; j++) begin
            if (blk_q == KW'(j)) begin
                blk_a = a_q[j*BW +: BW];
                blk_b = b_q[j*BW +: BW];
            end
        end
        blk_g    = blk_a & blk_b;
        blk_p    = blk_a ^ blk_b;
        blk_c    = '0;
        blk_c[0] = cy_q;
        for (int i = 0; i < BW; i++) begin
            c_acc = cy_q;
            for (int j = 0; j <= i; j++) begin
                c_acc = blk_g[j] | (blk_p[j] & c_acc);
            end
            blk_c[i+1] = c_acc;
        end
        blk_sum = blk_p ^ blk_c[BW-1:0];
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        oid_d   = oid_q;
        ov_d    = ov_q;
        cy_d    = cy_q;
        last_d  = last_q;
        blk_d   = blk_q;
        case (state_q)
            IDLE: begin
                if (acc0 || acc1) begin
                    a_d            = '0;
                    a_d[XW-1:0]    = acc1 ? X1 : X0;
                    b_d            = acc1 ? Y1 : Y0;
                    oid_d          = acc1;
                    last_d         = acc1;
                    blk_d          = '0;
                    cy_d           = 1'b0;
                    s_d            = '0;
                    state_d        = CALC;
                end
            end
            CALC: begin
                for (int j = 0; j < NB; j++) begin
                    if (blk_q == KW'(j)) begin
                        s_d[j*BW +: BW] = blk_sum;
                    end
                end
                cy_d = blk_c[BW];
                if (blk_q == KW'(NB - 1)) begin
                    s_d[YW] = blk_c[BW];
                    cy_d    = 1'b0;
                    blk_d   = '0;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            DONE: begin
                if (ov_q && OR) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            oid_q   <= 1'b0;
            ov_q    <= 1'b0;
            cy_q    <= 1'b0;
            last_q  <= 1'b1;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            oid_q   <= oid_d;
            ov_q    <= ov_d;
            cy_q    <= cy_d;
            last_q  <= last_d;
            blk_q   <= blk_d;
        end
    end

    assign S   = s_q;
    assign OID = oid_q;
    assign OV  = ov_q;

endmodule

// File: tb/tb_ubrcl_seq_arb.sv
// Directed bench for ubrcl_seq_arb: vector table plus corner-case sequences.
module tb_ubrcl_seq_arb;

    logic        CLK;
    logic        RST;
    logic [7:0]  X0;
    logic [11:0] Y0;
    logic        V0;
    logic        R0;
    logic [7:0]  X1;
    logic [11:0] Y1;
    logic        V1;
    logic        R1;
    logic [12:0] S;
    logic        OID;
    logic        OV;
    logic        OR;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          id;
        logic [7:0]  x;
        logic [11:0] y;
        logic [12:0] s;
    } vec_t;

    vec_t vecs[7];

    ubrcl_seq_arb #(.XW(8), .YW(12), .BW(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .X0  (X0),
        .Y0  (Y0),
        .V0  (V0),
        .R0  (R0),
        .X1  (X1),
        .Y1  (Y1),
        .V1  (V1),
        .R1  (R1),
        .S   (S),
        .OID (OID),
        .OV  (OV),
        .OR  (OR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Wait for OV with a cycle bound; returns cycles waited.
    task automatic wait_ov(output int n);
        n = 0;
        while (!OV && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_req(input bit id, input logic [7:0] x, input logic [11:0] y,
                          input logic [12:0] exp_s, input string tag);
        int n;
        if (!id) begin
            X0 = x; Y0 = y; V0 = 1'b1;
        end else begin
            X1 = x; Y1 = y; V1 = 1'b1;
        end
        #1;
        chk({tag, " ready"}, 32'(id ? R1 : R0), 32'd1);
        tick();
        V0 = 1'b0;
        V1 = 1'b0;
        wait_ov(n);
        chk({tag, " latency"}, 32'(n), 32'd3);
        chk({tag, " sum"}, 32'(S), 32'(exp_s));
        chk({tag, " oid"}, 32'(OID), 32'(id));
        tick();
        chk({tag, " ov_clear"}, 32'(OV), 32'd0);
    endtask

    initial begin
        int          n;
        int          n_done;
        int          last_acc;
        int          ov_seen;
        logic [12:0] exp_q[$];
        logic [12:0] e;

        vecs[0] = '{1'b0, 8'hFF, 12'hFFF, 13'h10FE};
        vecs[1] = '{1'b1, 8'h80, 12'h080, 13'h0100};
        vecs[2] = '{1'b0, 8'h00, 12'h000, 13'h0000};
        vecs[3] = '{1'b1, 8'hFF, 12'hF01, 13'h1000};
        vecs[4] = '{1'b0, 8'h0F, 12'h0F1, 13'h0100};
        vecs[5] = '{1'b1, 8'h01, 12'hFFF, 13'h1000};
        vecs[6] = '{1'b0, 8'hA5, 12'h5A5, 13'h064A};

        RST = 1'b1;
        X0 = '0; Y0 = '0; V0 = 1'b0;
        X1 = '0; Y1 = '0; V1 = 1'b0;
        OR = 1'b1;
        repeat (2) tick();

        // Reset state, with ready forced low while reset is held.
        V0 = 1'b1; V1 = 1'b1;
        #1;
        chk("reset S", 32'(S), 32'd0);
        chk("reset OID", 32'(OID), 32'd0);
        chk("reset OV", 32'(OV), 32'd0);
        chk("reset ready", 32'({R0, R1}), 32'd0);
        V0 = 1'b0; V1 = 1'b0;
        RST = 1'b0;
        #1;

        // Back-to-back ties from reset alternate starting with requester 0.
        X0 = 8'h12; Y0 = 12'h345; X1 = 8'h00; Y1 = 12'h000;
        V0 = 1'b1; V1 = 1'b1;
        #1;
        chk("tie1 ready", 32'({R0, R1}), 32'b10);
        tick();
        wait_ov(n);
        chk("tie1 latency", 32'(n), 32'd3);
        chk("tie1 sum", 32'(S), 32'h357);
        chk("tie1 oid", 32'(OID), 32'd0);
        chk("tie1 busy ready", 32'({R0, R1}), 32'd0);
        tick();
        chk("tie2 ready", 32'({R0, R1}), 32'b01);
        tick();
        wait_ov(n);
        chk("tie2 latency", 32'(n), 32'd3);
        chk("tie2 sum", 32'(S), 32'h000);
        chk("tie2 oid", 32'(OID), 32'd1);
        tick();
        chk("tie3 ready", 32'({R0, R1}), 32'b10);
        V0 = 1'b0; V1 = 1'b0;
        #1;

        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].s, $sformatf("vec%0d", i));
        end

        // Consumer stalls for 5 cycles; result must hold.
        OR = 1'b0;
        X1 = 8'h80; Y1 = 12'h080; V1 = 1'b1;
        #1;
        tick();
        V1 = 1'b0;
        wait_ov(n);
        chk("stall latency", 32'(n), 32'd3);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall sum c%0d", k), 32'(S), 32'h100);
            chk($sformatf("stall oid c%0d", k), 32'(OID), 32'd1);
            chk($sformatf("stall ov c%0d", k), 32'(OV), 32'd1);
            chk($sformatf("stall ready c%0d", k), 32'({R0, R1}), 32'd0);
            tick();
        end
        OR = 1'b1;
        #1;
        chk("stall ov before release", 32'(OV), 32'd1);
        tick();
        chk("stall ov after release", 32'(OV), 32'd0);
        chk("stall idle ready", 32'(R0), 32'd1);

        // Reset pulsed in the second CALC cycle discards the operation.
        X0 = 8'h12; Y0 = 12'h345; V0 = 1'b1;
        #1;
        tick();
        V0 = 1'b0;
        tick();
        RST = 1'b1;
        V0 = 1'b1; V1 = 1'b1;
        #1;
        chk("midreset ready", 32'({R0, R1}), 32'd0);
        tick();
        RST = 1'b0;
        V0 = 1'b0; V1 = 1'b0;
        #1;
        chk("midreset S", 32'(S), 32'd0);
        chk("midreset OID", 32'(OID), 32'd0);
        chk("midreset OV", 32'(OV), 32'd0);
        ov_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (OV) ov_seen++;
            tick();
        end
        chk("midreset no OV", 32'(ov_seen), 32'd0);
        V0 = 1'b1; V1 = 1'b1;
        #1;
        chk("midreset tie pointer", 32'({R0, R1}), 32'b10);
        V0 = 1'b0; V1 = 1'b0;
        #1;
        do_req(1'b1, 8'h80, 12'h080, 13'h100, "post-reset");

        // V0 held high with operands changing every cycle.
        n_done   = 0;
        last_acc = -1;
        for (int c = 0; c < 60 && n_done < 4; c++) begin
            X0 = 8'($urandom);
            Y0 = 12'($urandom);
            V0 = 1'b1;
            #1;
            if (OV) begin
                if (exp_q.size() == 0) begin
                    chk("stream unexpected result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream sum %0d", n_done), 32'(S), 32'(e));
                    chk($sformatf("stream oid %0d", n_done), 32'(OID), 32'd0);
                end
                n_done++;
            end
            if (R0) begin
                exp_q.push_back(13'(X0) + 13'(Y0));
                if (last_acc >= 0) begin
                    chk("stream spacing", 32'(c - last_acc), 32'd5);
                end
                last_acc = c;
            end
            tick();
        end
        V0 = 1'b0;
        chk("stream results", 32'(n_done), 32'd4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
